fb_hazard_ctrl: RTL

//  Pipeline hazard/stall controller that drives the write-enable, flush and bubble (lock) inputs of the
//  PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards in ID, taken

---
 rtl/fb_hazard_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fb_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flush and data-memory wait freeze.
// Outputs are Mealy; the FSM only remembers multi-cycle stalls.
module fb_hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned MEM_TIMEOUT    = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_register_rs1,
    input  logic [4:0]  id_register_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_register_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        ifid_flush,
    output logic        idex_lock,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        P_FREEZE,
        P_BUBBLE,
        P_FLUSH,
        P_GO
    } pat_e;

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] LUS_C = CNT_W'(LOAD_USE_STALL);
    localparam logic [CNT_W-1:0] MT_C  = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;
    logic             mem_timeout_q;
    logic             timeout_set;
    logic [31:0]      stall_cycles_q;
    logic             mem_stall;
    logic             load_use;
    logic             do_run;
    pat_e             pat;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_register_rd != 5'd0) &
                       ((id_use_rs1 & (id_register_rs1 == ex_register_rd)) |
                        (id_use_rs2 & (id_register_rs2 == ex_register_rd)));

    always_comb begin
        pat         = P_FREEZE;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bub_cnt_d   = bub_cnt_q;
        timeout_set = 1'b0;
        do_run      = 1'b0;

        case (state_q)
            RUN: do_run = 1'b1;
            LU_STALL: begin
                if (mem_stall) begin
                    pat        = P_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = ONE_C;
                end else begin
                    pat       = P_BUBBLE;
                    bub_cnt_d = bub_cnt_q + ONE_C;
                    if (bub_cnt_q + ONE_C == LUS_C) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt_q >= MT_C) begin
                        pat         = P_GO;
                        timeout_set = 1'b1;
                        state_d     = RUN;
                    end else begin
                        pat        = P_FREEZE;
                        wait_cnt_d = wait_cnt_q + ONE_C;
                    end
                end else begin
                    do_run = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // A completed memory wait falls through to the same decision RUN would make.
        if (do_run) begin
            state_d = RUN;
            if (mem_stall) begin
                pat        = P_FREEZE;
                state_d    = MEM_WAIT;
                wait_cnt_d = ONE_C;
            end else if (ex_branch_taken) begin
                pat = P_FLUSH;
            end else if (load_use) begin
                pat = P_BUBBLE;
                if (LOAD_USE_STALL > 1) begin
                    state_d   = LU_STALL;
                    bub_cnt_d = ONE_C;
                end
            end else begin
                pat = P_GO;
            end
        end

        if (rst) pat = P_FREEZE;
    end

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        memwb_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_lock  = 1'b0;
        case (pat)
            P_BUBBLE: begin
                idex_we   = 1'b1;
                idex_lock = 1'b1;
                exmem_we  = 1'b1;
                memwb_we  = 1'b1;
            end
            P_FLUSH: begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                idex_we    = 1'b1;
                exmem_we   = 1'b1;
                memwb_we   = 1'b1;
                ifid_flush = 1'b1;
                idex_lock  = 1'b1;
            end
            P_GO: begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                memwb_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            bub_cnt_q      <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bub_cnt_q  <= bub_cnt_d;
            if (timeout_set) mem_timeout_q <= 1'b1;
            if (!pc_we && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign state        = state_q;
    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule
